// File: rtl/boot_loader_if.sv
// Stream-in, CPU-side and memory-side bus bundle for the boot loader.
interface boot_loader_if;
  logic [0:7]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [15:31] cpu_address;
  logic [0:31]  cpu_data_out;
  logic [0:3]   cpu_write_en;
  logic [15:31] mem_address;
  logic [0:31]  mem_data_in;
  logic [0:3]   mem_write_en;

  // loader side
  modport slave (
    input  rx_data, rx_valid, cpu_address, cpu_data_out, cpu_write_en,
    output rx_ready, mem_address, mem_data_in, mem_write_en
  );

  // host / system side
  modport master (
    output rx_data, rx_valid, cpu_address, cpu_data_out, cpu_write_en,
    input  rx_ready, mem_address, mem_data_in, mem_write_en
  );
endinterface

// File: rtl/boot_loader.sv
// Byte-stream program loader: parses SETADDR/DATA/GO frames, writes
// big-endian words to memory, then hands the memory port to the CPU.
module boot_loader #(
  parameter logic [15:31] START_ADDR = 17'h0,
  parameter int           CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  boot_loader_if.slave     bus,
  output logic             o_cpu_active,
  output logic             o_load_error,
  output logic [CNT_W-1:0] o_words_loaded
);

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_WRITE, S_RUN} state_t;

  localparam logic [0:7] CMD_SETADDR = 8'h01;
  localparam logic [0:7] CMD_DATA    = 8'h02;
  localparam logic [0:7] CMD_GO      = 8'h03;

  state_t           r_state, w_next;
  logic [1:0]       r_cnt;
  logic [15:31]     r_addr;
  logic [0:31]      r_shift;
  logic             r_active, r_err;
  logic [CNT_W-1:0] r_words;
  logic             w_xfer;

  assign w_xfer         = bus.rx_valid & bus.rx_ready;
  assign o_cpu_active   = r_active;
  assign o_load_error   = r_err;
  assign o_words_loaded = r_words;

  // state register; async reset drops any in-flight frame or write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_CMD;
    else       r_state <= w_next;
  end

  // next state plus memory-port / ready muxing
  always_comb begin
    w_next           = r_state;
    bus.rx_ready     = 1'b0;
    bus.mem_write_en = 4'h0;
    bus.mem_address  = r_addr;
    bus.mem_data_in  = '0;
    case (r_state)
      S_CMD: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_SETADDR: w_next = S_ADDR;
            CMD_DATA:    w_next = S_DATA;
            CMD_GO:      w_next = S_RUN;
            default:     w_next = S_CMD;
          endcase
        end
      end
      S_ADDR: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid && r_cnt == 2'd2) w_next = S_CMD;
      end
      S_DATA: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid && r_cnt == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        bus.mem_write_en = 4'hF;
        bus.mem_data_in  = r_shift;
        w_next           = S_CMD;
      end
      S_RUN: begin
        // CPU owns memory with no added latency
        bus.mem_write_en = bus.cpu_write_en;
        bus.mem_address  = bus.cpu_address;
        bus.mem_data_in  = bus.cpu_data_out;
      end
      default: w_next = S_CMD;
    endcase
  end

  // datapath: byte shifter, address counter, status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= 2'd0;
      r_addr   <= START_ADDR;
      r_shift  <= '0;
      r_active <= 1'b0;
      r_err    <= 1'b0;
      r_words  <= '0;
    end else begin
      case (r_state)
        S_CMD: if (w_xfer) begin
          case (bus.rx_data)
            CMD_SETADDR, CMD_DATA: begin
              r_cnt   <= 2'd0;
              r_shift <= '0;
            end
            CMD_GO:  r_active <= 1'b1;
            default: r_err    <= 1'b1;
          endcase
        end
        S_ADDR: if (w_xfer) begin
          r_shift <= {r_shift[8:31], bus.rx_data};
          r_cnt   <= r_cnt + 2'd1;
          // 24-bit big-endian value, keep the low 17 bits
          if (r_cnt == 2'd2) r_addr <= {r_shift[23:31], bus.rx_data};
        end
        S_DATA: if (w_xfer) begin
          r_shift <= {r_shift[8:31], bus.rx_data};
          r_cnt   <= r_cnt + 2'd1;
        end
        S_WRITE: begin
          r_addr  <= r_addr + 17'd1;
          r_words <= r_words + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized + directed bench for boot_loader against a frame-level model.
module tb_boot_loader;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  boot_loader_if bus();
  logic        cpu_active, load_error;
  logic [15:0] words;

  boot_loader #(.START_ADDR(17'h0), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .o_cpu_active(cpu_active), .o_load_error(load_error), .o_words_loaded(words)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---- frame-level model: collect frame bytes, act when a frame completes
  logic [7:0]  fb [0:4];
  int          fn;
  logic        m_running, m_writing, m_err;
  logic [16:0] m_addr;
  logic [31:0] m_wdata;
  logic [15:0] m_words;
  wire         m_ready = !m_running && !m_writing;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      fn <= 0; m_running <= 1'b0; m_writing <= 1'b0; m_err <= 1'b0;
      m_addr <= 17'h0; m_wdata <= 32'h0; m_words <= 16'h0;
    end else if (m_writing) begin
      m_writing <= 1'b0;
      m_addr    <= m_addr + 17'd1;
      m_words   <= m_words + 16'd1;
    end else if (!m_running && bus.rx_valid) begin
      if (fn == 0) begin
        if (bus.rx_data == 8'h01 || bus.rx_data == 8'h02) begin
          fb[0] <= bus.rx_data; fn <= 1;
        end else if (bus.rx_data == 8'h03) m_running <= 1'b1;
        else m_err <= 1'b1;
      end else begin
        fb[fn] <= bus.rx_data;
        if (fb[0] == 8'h01 && fn == 3) begin
          m_addr <= {fb[1][0], fb[2], bus.rx_data};
          fn <= 0;
        end else if (fb[0] == 8'h02 && fn == 4) begin
          m_wdata   <= {fb[1], fb[2], fb[3], bus.rx_data};
          m_writing <= 1'b1;
          fn <= 0;
        end else fn <= fn + 1;
      end
    end
  end

  // ---- write logs: {addr, data}
  logic [48:0] mlog[$];
  logic [48:0] dlog[$];

  // per-cycle compare of every output against the model
  always @(negedge clock) begin
    if (!reset) begin
      chk("rx_ready", bus.rx_ready, m_ready);
      chk("cpu_active", cpu_active, m_running);
      chk("load_error", load_error, m_err);
      chk("words_loaded", words, m_words);
      chk("mem_write_en", bus.mem_write_en,
          m_running ? bus.cpu_write_en : (m_writing ? 4'hF : 4'h0));
      chk("mem_address", bus.mem_address, m_running ? bus.cpu_address : m_addr);
      chk("mem_data_in", bus.mem_data_in,
          m_running ? bus.cpu_data_out : (m_writing ? m_wdata : 32'h0));
      if (m_writing) mlog.push_back({m_addr, m_wdata});
      if (!cpu_active && bus.mem_write_en != 4'h0)
        dlog.push_back({bus.mem_address, bus.mem_data_in});
    end
  end

  task automatic rnd_cpu();
    bus.cpu_address  = 17'($urandom);
    bus.cpu_data_out = $urandom;
    bus.cpu_write_en = 4'($urandom);
  endtask

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      rnd_cpu();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
  endtask

  task automatic tick_run(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      rnd_cpu();
      bus.rx_valid = 1'($urandom);
      bus.rx_data  = 8'($urandom);
    end
  endtask

  // hold the byte until the model says it was taken (bounded)
  task automatic send(logic [7:0] b);
    logic acc = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int k = 0; k < 30 && !acc; k++) begin
      @(posedge clock);
      acc = m_ready;
      #1;
      rnd_cpu();
    end
    bus.rx_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic send_data(logic [31:0] w);
    send(8'h02); send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
  endtask

  task automatic do_reset();
    @(posedge clock); #3;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_we", bus.mem_write_en, 0);
    chk("rst_active", cpu_active, 0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_words", words, 0);
    chk("rst_err", load_error, 0);
    mlog.delete();
    dlog.delete();
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic chk_log(string nm, int idx, logic [16:0] a, logic [31:0] d);
    chk({nm, "_model"}, idx < mlog.size() ? mlog[idx] : '1, {a, d});
    chk({nm, "_dut"},   idx < dlog.size() ? dlog[idx] : '1, {a, d});
  endtask

  initial begin
    logic [7:0] b;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h0;
    bus.cpu_address = '0; bus.cpu_data_out = '0; bus.cpu_write_en = '0;

    // T1: set address, one word, go, CPU passthrough
    do_reset();
    send(8'h01); send(8'h00); send(8'h00); send(8'h10);
    send_data(32'hDEADBEEF);
    send(8'h03);
    bus.cpu_address = 17'h20; bus.cpu_write_en = 4'b0011; bus.cpu_data_out = 32'hCAFE0001;
    @(negedge clock);
    chk("t1_active", cpu_active, 1);
    chk("t1_ready", bus.rx_ready, 0);
    chk("t1_pass_addr", bus.mem_address, 17'h20);
    chk("t1_pass_we", bus.mem_write_en, 4'b0011);
    chk("t1_pass_data", bus.mem_data_in, 32'hCAFE0001);
    chk("t1_words", words, 1);
    chk("t1_nlog_dut", dlog.size(), 1);
    chk("t1_nlog_model", mlog.size(), 1);
    chk_log("t1_w0", 0, 17'h10, 32'hDEADBEEF);
    tick_run(6);

    // T2: three words from reset land at 0,1,2
    do_reset();
    send_data(32'h11223344); send_data(32'h55667788); send_data(32'h99AABBCC);
    tick(3);
    chk("t2_words", words, 3);
    chk("t2_nlog_dut", dlog.size(), 3);
    chk_log("t2_w0", 0, 17'h0, 32'h11223344);
    chk_log("t2_w1", 1, 17'h1, 32'h55667788);
    chk_log("t2_w2", 2, 17'h2, 32'h99AABBCC);

    // T3: address wrap
    do_reset();
    send(8'h01); send(8'h01); send(8'hFF); send(8'hFF);
    send_data(32'hA5A5A5A5); send_data(32'h5A5A5A5A);
    tick(3);
    chk_log("t3_w0", 0, 17'h1FFFF, 32'hA5A5A5A5);
    chk_log("t3_w1", 1, 17'h00000, 32'h5A5A5A5A);

    // T4: bad command is sticky, next frame still writes
    do_reset();
    send(8'h7F);
    tick(2);
    chk("t4_err", load_error, 1);
    chk("t4_nowrite", dlog.size(), 0);
    send_data(32'h01020304);
    tick(3);
    chk_log("t4_w0", 0, 17'h0, 32'h01020304);
    chk("t4_err_hold", load_error, 1);

    // T5: reset mid-frame discards the partial word
    do_reset();
    send(8'h02); send(8'hAA); send(8'hBB);
    do_reset();
    chk("t5_nowrite", dlog.size(), 0);
    send_data(32'h11223344);
    tick(3);
    chk("t5_words", words, 1);
    chk("t5_nlog", dlog.size(), 1);
    chk_log("t5_w0", 0, 17'h0, 32'h11223344);

    // T6: CPU writes dropped before GO, passed after
    do_reset();
    tick(1);
    bus.cpu_address = 17'h20; bus.cpu_write_en = 4'b0011;
    @(negedge clock);
    chk("t6_pre_we", bus.mem_write_en, 0);
    chk("t6_pre_addr", bus.mem_address, 0);
    send(8'h03);
    bus.cpu_address = 17'h20; bus.cpu_write_en = 4'b0011;
    @(negedge clock);
    chk("t6_post_we", bus.mem_write_en, 4'b0011);
    chk("t6_post_addr", bus.mem_address, 17'h20);

    // T7: random frame mix, random gaps, then GO and random run traffic
    do_reset();
    for (int f = 0; f < 60; f++) begin
      int r;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 2));
      if (r == 0) begin
        b = 8'($urandom);
        if (b == 8'h01 || b == 8'h02 || b == 8'h03) b = 8'h7F;
        send(b);
      end else if (r < 3) begin
        send(8'h01);
        if ($urandom_range(0, 3) == 0) begin
          send(8'($urandom)); send(8'hFF); send(8'hFE);
        end else begin
          send(8'($urandom)); send(8'($urandom)); send(8'($urandom));
        end
      end else begin
        send(8'h02);
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(0, 3) == 0) tick(1);
          send(8'($urandom));
        end
      end
    end
    tick(2);
    send(8'h03);
    tick_run(30);
    chk("t7_nlog", dlog.size(), mlog.size());
    for (int i = 0; i < dlog.size() && i < mlog.size(); i++)
      chk("t7_log", dlog[i], mlog[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
